cross_arbiter: RTL and testbench

Shared signed cross-product engine with a round-robin arbiter. It serves NREQ requesters, for example the hull-sort sequencer and the point-inside test sequencer of the geofence datapath. Each accepted request computes (A-O)x(B-O) through a 3-stage pipeline and returns the sign flags tagged with the requester id. It replaces per-engine multiplier pairs with one shared multiplier pair.

---
 rtl/geofence_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 47 ++++
 rtl/cross_arbiter.sv | 174 +++++++++++++++++
 tb/tb_cross_arbiter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/geofence_pkg.sv
// Shared geofence datapath definitions: coordinate/derived widths and requester ids.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package geofence_pkg;

  localparam int COORD_W = 10;
  localparam int DIFF_W  = COORD_W + 1;
  localparam int PROD_W  = 2 * COORD_W + 2;

  typedef enum logic [0:0] {
    REQ_SORT   = 1'b0,
    REQ_INSIDE = 1'b1
  } req_id_e;

  // Width of a requester index; never below one bit.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the lowest-index requester at or after ptr_i, wrapping.
// Latency: combinational.
// Backpressure: en_i low forces gnt_o to zero.
//
// Ports:
//   req_i     per-requester request
//   en_i      grant enable (low while the consumer stalls or reset is held)
//   ptr_i     round-robin start index
//   gnt_o     one-hot grant
//   gnt_idx_o binary index of the granted requester (0 when no grant)
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic            en_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  gnt_idx_o
);

  logic [NREQ-1:0] upper;
  logic [NREQ-1:0] pick;

  always_comb begin
    upper     = '0;
    pick      = '0;
    gnt_o     = '0;
    gnt_idx_o = '0;
    // Requests at or after the pointer take priority; otherwise wrap to the bottom.
    for (int i = 0; i < NREQ; i++) begin
      upper[i] = req_i[i] && (i >= int'(ptr_i));
    end
    pick = (|upper) ? upper : req_i;
    if (en_i) begin
      // Scan high to low so the lowest set bit is the last one written.
      for (int i = NREQ - 1; i >= 0; i--) begin
        if (pick[i]) begin
          gnt_o     = '0;
          gnt_o[i]  = 1'b1;
          gnt_idx_o = IDW'(i);
        end
      end
    end
  end

endmodule

// File: rtl/cross_arbiter.sv
// Shared signed cross-product engine: round-robin grants NREQ requesters, computes (A-O)x(B-O) sign flags.
// Latency: 3 cycles from grant to rsp_valid; one result per cycle.
// Backpressure: rsp_valid & ~rsp_ready stalls every stage and blocks new grants.
//
// Ports:
//   clk, reset_n        clock (rising edge), asynchronous active-low reset
//   req                 per-requester request, held until granted
//   op_ox..op_by        packed operands, requester i in slice [i*W +: W]
//   gnt                 one-hot grant; operands are sampled in the grant cycle
//   rsp_valid/rsp_ready result handshake
//   rsp_id              requester index of the result
//   rsp_gt, rsp_eq      (Ax*By) > (Bx*Ay), (Ax*By) == (Bx*Ay)
//   rsp_cross           signed P-Q, present only when CROSS_ARB_RAW_EN is defined
module cross_arbiter
  import geofence_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int W    = COORD_W
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*W-1:0]       op_ox,
  input  logic [NREQ*W-1:0]       op_oy,
  input  logic [NREQ*W-1:0]       op_ax,
  input  logic [NREQ*W-1:0]       op_ay,
  input  logic [NREQ*W-1:0]       op_bx,
  input  logic [NREQ*W-1:0]       op_by,
  output logic [NREQ-1:0]         gnt,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [id_w(NREQ)-1:0]   rsp_id,
  output logic                    rsp_gt,
  output logic                    rsp_eq
`ifdef CROSS_ARB_RAW_EN
  ,
  output logic signed [2*W+2:0]   rsp_cross
`endif
);

  localparam int IDW = id_w(NREQ);
  localparam int DW  = W + 1;
  localparam int PW  = 2 * W + 2;

  logic           stall;
  logic           arb_en;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] gnt_idx;

  logic [W-1:0]   sel_ox, sel_oy, sel_ax, sel_ay, sel_bx, sel_by;

  logic signed [DW-1:0] s1_ax_d, s1_ay_d, s1_bx_d, s1_by_d;
  logic signed [DW-1:0] s1_ax_q, s1_ay_q, s1_bx_q, s1_by_q;
  logic                 s1_vld_q;
  logic [IDW-1:0]       s1_id_q;

  logic signed [PW-1:0] s2_p_d, s2_q_d;
  logic signed [PW-1:0] s2_p_q, s2_q_q;
  logic                 s2_vld_q;
  logic [IDW-1:0]       s2_id_q;

  logic                 rsp_valid_q;
  logic [IDW-1:0]       rsp_id_q;
  logic                 rsp_gt_q;
  logic                 rsp_eq_q;

  assign stall  = rsp_valid_q & ~rsp_ready;
  // Gating with reset_n keeps gnt at zero while reset is held.
  assign arb_en = ~stall & reset_n;

  rr_arbiter #(
    .NREQ(NREQ),
    .IDW (IDW)
  ) u_rr_arbiter (
    .req_i    (req),
    .en_i     (arb_en),
    .ptr_i    (ptr_q),
    .gnt_o    (gnt),
    .gnt_idx_o(gnt_idx)
  );

  // One-hot operand mux driven directly by the grant vector.
  always_comb begin
    sel_ox = '0;
    sel_oy = '0;
    sel_ax = '0;
    sel_ay = '0;
    sel_bx = '0;
    sel_by = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_ox = op_ox[i*W +: W];
        sel_oy = op_oy[i*W +: W];
        sel_ax = op_ax[i*W +: W];
        sel_ay = op_ay[i*W +: W];
        sel_bx = op_bx[i*W +: W];
        sel_by = op_by[i*W +: W];
      end
    end
  end

  // Zero-extended unsigned operands give exact W+1-bit signed differences.
  assign s1_ax_d = $signed({1'b0, sel_ax}) - $signed({1'b0, sel_ox});
  assign s1_ay_d = $signed({1'b0, sel_ay}) - $signed({1'b0, sel_oy});
  assign s1_bx_d = $signed({1'b0, sel_bx}) - $signed({1'b0, sel_ox});
  assign s1_by_d = $signed({1'b0, sel_by}) - $signed({1'b0, sel_oy});

  // Sign-extend before multiplying so the full product width is kept.
  assign s2_p_d = PW'(s1_ax_q) * PW'(s1_by_q);
  assign s2_q_d = PW'(s1_bx_q) * PW'(s1_ay_q);

  always_comb begin
    ptr_d = ptr_q;
    if (|gnt) begin
      ptr_d = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q       <= '0;
      s1_vld_q    <= 1'b0;
      s1_id_q     <= '0;
      s1_ax_q     <= '0;
      s1_ay_q     <= '0;
      s1_bx_q     <= '0;
      s1_by_q     <= '0;
      s2_vld_q    <= 1'b0;
      s2_id_q     <= '0;
      s2_p_q      <= '0;
      s2_q_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_gt_q    <= 1'b0;
      rsp_eq_q    <= 1'b0;
    end else if (!stall) begin
      ptr_q       <= ptr_d;
      s1_vld_q    <= |gnt;
      s1_id_q     <= gnt_idx;
      s1_ax_q     <= s1_ax_d;
      s1_ay_q     <= s1_ay_d;
      s1_bx_q     <= s1_bx_d;
      s1_by_q     <= s1_by_d;
      s2_vld_q    <= s1_vld_q;
      s2_id_q     <= s1_id_q;
      s2_p_q      <= s2_p_d;
      s2_q_q      <= s2_q_d;
      rsp_valid_q <= s2_vld_q;
      rsp_id_q    <= s2_id_q;
      rsp_gt_q    <= (s2_p_q > s2_q_q);
      rsp_eq_q    <= (s2_p_q == s2_q_q);
    end
  end

`ifdef CROSS_ARB_RAW_EN
  logic signed [PW:0] rsp_cross_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_cross_q <= '0;
    end else if (!stall) begin
      rsp_cross_q <= (PW + 1)'(s2_p_q) - (PW + 1)'(s2_q_q);
    end
  end

  assign rsp_cross = rsp_cross_q;
`endif

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_gt    = rsp_gt_q;
  assign rsp_eq    = rsp_eq_q;

endmodule

// File: tb/tb_cross_arbiter.sv
// Directed table-driven bench for cross_arbiter (NREQ=2, W=10).
// Inputs are driven on the falling edge, outputs sampled 1 time unit later.
// Rows are one cycle each; expected results reference a hand-computed operand-set table.
module tb_cross_arbiter;

  localparam int NREQ = 2;
  localparam int W    = 10;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] op_ox, op_oy, op_ax, op_ay, op_bx, op_by;
  logic [NREQ-1:0]   gnt;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [0:0]        rsp_id;
  logic              rsp_gt;
  logic              rsp_eq;
`ifdef CROSS_ARB_RAW_EN
  logic signed [2*W+2:0] rsp_cross;
`endif

  always #5 clk = ~clk;

  cross_arbiter #(
    .NREQ(NREQ),
    .W   (W)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .req      (req),
    .op_ox    (op_ox),
    .op_oy    (op_oy),
    .op_ax    (op_ax),
    .op_ay    (op_ay),
    .op_bx    (op_bx),
    .op_by    (op_by),
    .gnt      (gnt),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_id   (rsp_id),
    .rsp_gt   (rsp_gt),
    .rsp_eq   (rsp_eq)
`ifdef CROSS_ARB_RAW_EN
    ,
    .rsp_cross(rsp_cross)
`endif
  );

  // Operand sets with hand-computed results.
  // 0: O(0,0) A(4,0) B(0,3)            P=12 Q=0        -> gt
  // 1: O(0,0) A(0,3) B(4,0)            P=0  Q=12       -> lt
  // 2: O(1,1) A(3,3) B(5,5)            P=8  Q=8        -> eq
  // 3: O(1023,0) A(0,1023) B(1023,1023) P=-1046529 Q=0 -> lt
  // 4: O(0,0) A(1023,0) B(0,1023)      P=1046529 Q=0   -> gt
  int set_ox [5] = '{0, 0, 1, 1023, 0};
  int set_oy [5] = '{0, 0, 1, 0, 0};
  int set_ax [5] = '{4, 0, 3, 0, 1023};
  int set_ay [5] = '{0, 3, 3, 1023, 0};
  int set_bx [5] = '{0, 4, 5, 1023, 0};
  int set_by [5] = '{3, 0, 5, 1023, 1023};
  int set_gt [5] = '{1, 0, 0, 0, 1};
  int set_eq [5] = '{0, 0, 1, 0, 0};
  int set_cr [5] = '{12, -12, 0, -1046529, 1046529};

  typedef struct {
    logic [1:0] req;
    int         s0;
    int         s1;
    logic       rdy;
    logic [1:0] gnt;
    logic       vld;
    int         id;
    int         set;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input logic [1:0] r, input int s0, input int s1, input logic rdy,
                              input logic [1:0] g, input logic v, input int id, input int set);
    vec_t t;
    t.req = r;  t.s0 = s0; t.s1 = s1; t.rdy = rdy;
    t.gnt = g;  t.vld = v; t.id = id; t.set = set;
    return t;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_rsp(input string name, input int id, input int set);
    chk({name, " id"}, longint'(rsp_id), id);
    chk({name, " gt"}, longint'(rsp_gt), set_gt[set]);
    chk({name, " eq"}, longint'(rsp_eq), set_eq[set]);
`ifdef CROSS_ARB_RAW_EN
    chk({name, " cross"}, longint'(rsp_cross), set_cr[set]);
`endif
  endtask

  task automatic drive(input logic [1:0] r, input int s0, input int s1, input logic rdy);
    req       = r;
    rsp_ready = rdy;
    op_ox = {W'(set_ox[s1]), W'(set_ox[s0])};
    op_oy = {W'(set_oy[s1]), W'(set_oy[s0])};
    op_ax = {W'(set_ax[s1]), W'(set_ax[s0])};
    op_ay = {W'(set_ay[s1]), W'(set_ay[s0])};
    op_bx = {W'(set_bx[s1]), W'(set_bx[s0])};
    op_by = {W'(set_by[s1]), W'(set_by[s0])};
  endtask

  initial begin
    //                 req  s0 s1 rdy  gnt  vld id set
    vecs.push_back(mk(2'b01, 0, 0, 1, 2'b01, 0, 0, 0)); // 0 single request, same-cycle grant
    vecs.push_back(mk(2'b00, 0, 0, 1, 2'b00, 0, 0, 0)); // 1
    vecs.push_back(mk(2'b00, 0, 0, 1, 2'b00, 0, 0, 0)); // 2
    vecs.push_back(mk(2'b01, 1, 0, 1, 2'b01, 1, 0, 0)); // 3 row-0 result, ptr wraps to r0
    vecs.push_back(mk(2'b01, 2, 0, 1, 2'b01, 0, 0, 0)); // 4 bubble from row 1
    vecs.push_back(mk(2'b01, 3, 0, 1, 2'b01, 0, 0, 0)); // 5 bubble from row 2
    vecs.push_back(mk(2'b01, 4, 0, 1, 2'b01, 1, 0, 1)); // 6 swapped A/B
    vecs.push_back(mk(2'b00, 0, 0, 1, 2'b00, 1, 0, 2)); // 7 collinear
    vecs.push_back(mk(2'b00, 0, 0, 1, 2'b00, 1, 0, 3)); // 8 negative extreme
    vecs.push_back(mk(2'b00, 0, 0, 1, 2'b00, 1, 0, 4)); // 9 positive extreme
    vecs.push_back(mk(2'b10, 0, 0, 1, 2'b10, 0, 0, 0)); // 10 r1 alone, ptr -> 0
    vecs.push_back(mk(2'b11, 0, 1, 1, 2'b01, 0, 0, 0)); // 11 rotation starts
    vecs.push_back(mk(2'b11, 2, 3, 1, 2'b10, 0, 0, 0)); // 12
    vecs.push_back(mk(2'b11, 4, 1, 1, 2'b01, 1, 1, 0)); // 13 row-10 result
    vecs.push_back(mk(2'b11, 1, 2, 1, 2'b10, 1, 0, 0)); // 14
    vecs.push_back(mk(2'b11, 3, 4, 1, 2'b01, 1, 1, 3)); // 15
    vecs.push_back(mk(2'b11, 0, 0, 1, 2'b10, 1, 0, 4)); // 16
    vecs.push_back(mk(2'b11, 0, 0, 0, 2'b00, 1, 1, 2)); // 17 stall: no grant, output held
    vecs.push_back(mk(2'b11, 0, 0, 0, 2'b00, 1, 1, 2)); // 18
    vecs.push_back(mk(2'b11, 0, 0, 0, 2'b00, 1, 1, 2)); // 19
    vecs.push_back(mk(2'b11, 0, 0, 0, 2'b00, 1, 1, 2)); // 20
    vecs.push_back(mk(2'b00, 0, 0, 1, 2'b00, 1, 1, 2)); // 21 released, consumed here
    vecs.push_back(mk(2'b00, 0, 0, 1, 2'b00, 1, 0, 3)); // 22
    vecs.push_back(mk(2'b00, 0, 0, 1, 2'b00, 1, 1, 0)); // 23
    vecs.push_back(mk(2'b00, 0, 0, 1, 2'b00, 0, 0, 0)); // 24 valid drops

    // Reset held with every requester asserting.
    reset_n = 1'b0;
    drive(2'b11, 0, 1, 1'b1);
    @(negedge clk);
    #1;
    chk("reset gnt", longint'(gnt), 0);
    chk("reset rsp_valid", longint'(rsp_valid), 0);
    chk("reset rsp_id", longint'(rsp_id), 0);
    chk("reset rsp_gt", longint'(rsp_gt), 0);
    chk("reset rsp_eq", longint'(rsp_eq), 0);
`ifdef CROSS_ARB_RAW_EN
    chk("reset rsp_cross", longint'(rsp_cross), 0);
`endif

    @(negedge clk);
    reset_n = 1'b1;
    drive(2'b00, 0, 0, 1'b1);

    for (int k = 0; k < vecs.size(); k++) begin
      @(negedge clk);
      drive(vecs[k].req, vecs[k].s0, vecs[k].s1, vecs[k].rdy);
      #1;
      chk($sformatf("row%0d gnt", k), longint'(gnt), longint'(vecs[k].gnt));
      chk($sformatf("row%0d rsp_valid", k), longint'(rsp_valid), longint'(vecs[k].vld));
      if (vecs[k].vld) chk_rsp($sformatf("row%0d", k), vecs[k].id, vecs[k].set);
    end

    // Three results in flight, then reset mid-cycle.
    @(negedge clk); drive(2'b11, 0, 1, 1'b1); #1; chk("flight0 gnt", longint'(gnt), 1);
    @(negedge clk); drive(2'b11, 2, 3, 1'b1); #1; chk("flight1 gnt", longint'(gnt), 2);
    @(negedge clk); drive(2'b11, 4, 4, 1'b1); #1; chk("flight2 gnt", longint'(gnt), 1);
    @(negedge clk); drive(2'b00, 0, 0, 1'b1); #1;
    chk("flight rsp_valid", longint'(rsp_valid), 1);
    chk_rsp("flight", 0, 0);
    reset_n = 1'b0;
    #1;
    chk("midreset rsp_valid", longint'(rsp_valid), 0);
    chk("midreset gnt", longint'(gnt), 0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      chk($sformatf("post-reset idle%0d rsp_valid", k), longint'(rsp_valid), 0);
    end

    // Pointer returned to 0: both requesting must grant requester 0.
    @(negedge clk); drive(2'b11, 1, 0, 1'b1); #1;
    chk("post-reset gnt", longint'(gnt), 1);
    @(negedge clk); drive(2'b00, 0, 0, 1'b1); #1;
    chk("post-reset lat1 rsp_valid", longint'(rsp_valid), 0);
    @(negedge clk); #1;
    chk("post-reset lat2 rsp_valid", longint'(rsp_valid), 0);
    @(negedge clk); #1;
    chk("post-reset lat3 rsp_valid", longint'(rsp_valid), 1);
    chk_rsp("post-reset", 0, 1);
    @(negedge clk); #1;
    chk("post-reset drain rsp_valid", longint'(rsp_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
